// File: rtl/job_dispatcher.sv
// Job dispatcher: buffers job entries in a FIFO, launches one core run per entry,
// captures the core result (or a watchdog timeout) and offers it on a valid/ready port.
module job_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 4,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ENTRY_W-1:0]       in_entry,
  output logic                     in_ready,
  output logic                     core_start,
  output logic [ENTRY_W-1:0]       core_entry,
  input  logic                     core_done,
  input  logic [RES_W-1:0]         core_result,
  output logic                     out_valid,
  output logic [ENTRY_W-1:0]       out_entry,
  output logic [RES_W-1:0]         out_result,
  output logic                     out_timeout,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

  state_e state_q, state_d;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               push, pop;

  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [WdogW-1:0]   wdog_q, wdog_d;
  logic               done_q;
  logic               done_rise;

  logic               out_valid_q, out_valid_d;
  logic [ENTRY_W-1:0] out_entry_q, out_entry_d;
  logic [RES_W-1:0]   out_result_q, out_result_d;
  logic               out_timeout_q, out_timeout_d;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  assign in_ready = (count_q != CntW'(DEPTH));
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Pointer widths equal log2(DEPTH), so wrap-around is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Only a fresh 0->1 transition counts, so a done level held over from the
  // previous run cannot complete the new one.
  assign done_rise = core_done & ~done_q;

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    entry_d       = entry_q;
    wdog_d        = wdog_q;
    out_valid_d   = out_valid_q;
    out_entry_d   = out_entry_q;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          entry_d = mem_q[rd_ptr_q];
          state_d = StLaunch;
        end
      end

      StLaunch: begin
        wdog_d  = '0;
        state_d = StWait;
      end

      StWait: begin
        if (done_rise) begin
          out_valid_d   = 1'b1;
          out_entry_d   = entry_q;
          out_result_d  = core_result;
          out_timeout_d = 1'b0;
          state_d       = StHold;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
          if (wdog_d == WdogW'(TIMEOUT)) begin
            out_valid_d   = 1'b1;
            out_entry_d   = entry_q;
            out_result_d  = '1;
            out_timeout_d = 1'b1;
            state_d       = StHold;
          end
        end
      end

      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Chain straight into the next run when work is already queued.
          if (count_q != '0) begin
            pop     = 1'b1;
            entry_d = mem_q[rd_ptr_q];
            state_d = StLaunch;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      entry_q       <= '0;
      wdog_q        <= '0;
      done_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_entry_q   <= '0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      wdog_q        <= wdog_d;
      done_q        <= core_done;
      out_valid_q   <= out_valid_d;
      out_entry_q   <= out_entry_d;
      out_result_q  <= out_result_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign core_start  = (state_q == StLaunch);
  assign core_entry  = entry_q;
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign out_entry   = out_entry_q;
  assign out_result  = out_result_q;
  assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_job_dispatcher.sv
// Bench for job_dispatcher: a timestamp-level job model (arrival, launch, result,
// handshake cycles) predicts every output each cycle; directed phases plus random traffic.
module tb_job_dispatcher;

  localparam int DEPTH   = 4;
  localparam int EW      = 4;
  localparam int RW      = 8;
  localparam int TIMEOUT = 255;
  localparam int NEVER   = 1000;  // core latency meaning "never completes"
  localparam int MAXJ    = 2048;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [EW-1:0] in_entry;
  logic          in_ready;
  logic          core_start;
  logic [EW-1:0] core_entry;
  logic          core_done;
  logic [RW-1:0] core_result;
  logic          out_valid;
  logic [EW-1:0] out_entry;
  logic [RW-1:0] out_result;
  logic          out_timeout;
  logic          out_ready;
  logic          busy;
  logic [2:0]    fifo_count;

  job_dispatcher #(
    .DEPTH  (DEPTH),
    .ENTRY_W(EW),
    .RES_W  (RW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_entry   (in_entry),
    .in_ready   (in_ready),
    .core_start (core_start),
    .core_entry (core_entry),
    .core_done  (core_done),
    .core_result(core_result),
    .out_valid  (out_valid),
    .out_entry  (out_entry),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .out_ready  (out_ready),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-job model record: arrival, launch, first-valid and handshake cycles,
  // core behaviour (latency L, stale-hold D, result) and DUT observations.
  int          j_entry [MAXJ];
  int          j_a     [MAXJ];
  int          j_s     [MAXJ];
  int          j_v     [MAXJ];
  int          j_h     [MAXJ];
  int          j_l     [MAXJ];
  int          j_d     [MAXJ];
  int          j_res   [MAXJ];
  bit          j_stale [MAXJ];
  int          obs_start [MAXJ];
  int          obs_valid [MAXJ];
  int          obs_entry [MAXJ];
  int          obs_res   [MAXJ];
  int          obs_to    [MAXJ];

  int first     = 0;
  int n_jobs    = 0;
  int n_started = 0;
  int g_act     = -1;
  bit g_vexp    = 1'b0;
  bit done_lvl  = 1'b0;
  int n_dut_starts = 0;

  bit nx_rand = 1'b0;
  int nx_l    = 5;
  int nx_d    = 0;
  int nx_res  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic set_job(input int l, input int d, input int res);
    nx_l   = l;
    nx_d   = d;
    nx_res = res;
  endtask

  // One clock cycle: compare, then drive inputs, then record this cycle's events.
  task automatic step(input bit iv, input logic [EW-1:0] ie, input bit ordy);
    int act, cnt, nx, k, r, dmax;
    bit launch, vexp;
    @(negedge clk);
    cyc++;
    k      = 0;
    nx     = n_started;
    launch = 1'b0;
    // A job launches 2 cycles after its push and 1 cycle after the previous handshake.
    if (nx < n_jobs && j_a[nx] + 2 <= cyc) begin
      launch = (nx == first) || (j_h[nx-1] >= 0);
    end
    if (launch) begin
      j_s[nx]     = cyc;
      j_stale[nx] = done_lvl;
      j_v[nx]     = cyc + ((j_l[nx] <= TIMEOUT) ? j_l[nx] + 1 : TIMEOUT + 1);
      n_started++;
    end
    act  = (n_started > first && j_h[n_started-1] < 0) ? n_started - 1 : -1;
    cnt  = n_jobs - n_started;
    vexp = (act >= 0) && (cyc >= j_v[act]);

    chk("out_valid", out_valid, vexp);
    chk("busy", busy, act >= 0);
    chk("core_start", core_start, (act >= 0) && (j_s[act] == cyc));
    chk("fifo_count", fifo_count, cnt);
    chk("in_ready", in_ready, cnt < DEPTH);
    if (vexp) begin
      chk("out_entry", out_entry, j_entry[act]);
      chk("out_result", out_result, (j_l[act] <= TIMEOUT) ? j_res[act] : 255);
      chk("out_timeout", out_timeout, j_l[act] > TIMEOUT);
    end
    if (act >= 0 && cyc < j_v[act]) chk("core_entry", core_entry, j_entry[act]);

    if (core_start === 1'b1) begin
      n_dut_starts++;
      if (act >= 0 && obs_start[act] < 0) obs_start[act] = cyc;
    end
    if (out_valid === 1'b1 && act >= 0 && obs_valid[act] < 0) begin
      obs_valid[act] = cyc;
      obs_entry[act] = int'(out_entry);
      obs_res[act]   = int'(out_result);
      obs_to[act]    = int'(out_timeout);
    end

    // Core model: stale level for D cycles after launch, low, then high from L on.
    if (act >= 0) begin
      k = cyc - j_s[act];
      if (k < j_d[act]) done_lvl = j_stale[act];
      else              done_lvl = (k >= j_l[act]);
    end
    core_done   = done_lvl;
    core_result = (act >= 0 && done_lvl && k >= j_l[act]) ? RW'(j_res[act]) : RW'($urandom);
    in_valid    = iv;
    in_entry    = ie;
    out_ready   = ordy;

    if (iv && cnt < DEPTH) begin
      j_entry[n_jobs]   = int'(ie);
      j_a[n_jobs]       = cyc;
      j_h[n_jobs]       = -1;
      obs_start[n_jobs] = -1;
      obs_valid[n_jobs] = -1;
      if (nx_rand) begin
        r = int'($urandom_range(0, 99));
        if (r < 3)      j_l[n_jobs] = NEVER;
        else if (r < 5) j_l[n_jobs] = TIMEOUT;
        else            j_l[n_jobs] = int'($urandom_range(1, 25));
        dmax = (j_l[n_jobs] == NEVER) ? 6 : ((j_l[n_jobs] - 1 < 6) ? j_l[n_jobs] - 1 : 6);
        j_d[n_jobs]   = int'($urandom_range(0, dmax));
        j_res[n_jobs] = int'($urandom_range(0, 255));
      end else begin
        j_l[n_jobs]   = nx_l;
        j_d[n_jobs]   = nx_d;
        j_res[n_jobs] = nx_res;
      end
      n_jobs++;
    end
    if (vexp && ordy) j_h[act] = cyc;
    g_act  = act;
    g_vexp = vexp;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    while (!(n_started == n_jobs && g_act < 0) && i < bound) begin
      step(1'b0, 4'd0, 1'b1);
      i++;
    end
    chk("idle_reached", (n_started == n_jobs && g_act < 0), 1);
  endtask

  initial begin
    int j0, jb, ja, jx, jy, jt, jn, jz, s0, h_cyc;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_entry    = '0;
    core_done   = 1'b0;
    core_result = '0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_core_entry", core_entry, 0);
    rst = 1'b1;
    repeat (3) step(1'b0, 4'd0, 1'b1);

    // 1: single job, done 10 cycles after start
    s0 = n_dut_starts;
    set_job(10, 0, 132);
    j0 = n_jobs;
    step(1'b1, 4'd6, 1'b1);
    wait_idle(100);
    chk("t1_start_count", n_dut_starts - s0, 1);
    chk("t1_start_latency", obs_start[j0] - j_a[j0], 2);
    chk("t1_valid_latency", obs_valid[j0] - obs_start[j0], 11);
    chk("t1_entry", obs_entry[j0], 6);
    chk("t1_result", obs_res[j0], 132);
    chk("t1_timeout", obs_to[j0], 0);

    // 2: fill the FIFO while the core is stalled on a long run
    set_job(60, 0, 8'h90);
    jb = n_jobs;
    step(1'b1, 4'd9, 1'b1);
    repeat (3) step(1'b0, 4'd0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      set_job(2 + i, 0, 16 * i);
      step(1'b1, EW'(i), 1'b1);
    end
    step(1'b0, 4'd0, 1'b1);
    chk("t2_fifo_full", fifo_count, 4);
    chk("t2_in_ready_low", in_ready, 0);
    chk("t2_accepted", n_jobs - jb, 5);
    wait_idle(400);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order_entry", obs_entry[jb + i], i);
      chk("t2_order_result", obs_res[jb + i], 16 * i);
    end

    // 3: backpressure with a queued job
    set_job(5, 0, 8'hC3);
    ja = n_jobs;
    step(1'b1, 4'd10, 1'b0);
    set_job(5, 0, 8'h3D);
    step(1'b1, 4'd11, 1'b0);
    for (int i = 0; i < 100 && !g_vexp; i++) step(1'b0, 4'd0, 1'b0);
    chk("t3_valid_seen", g_vexp, 1);
    s0 = n_dut_starts;
    repeat (20) step(1'b0, 4'd0, 1'b0);
    chk("t3_no_start_in_hold", n_dut_starts - s0, 0);
    chk("t3_held_result", out_result, 8'hC3);
    chk("t3_held_entry", out_entry, 10);
    step(1'b0, 4'd0, 1'b1);
    h_cyc = cyc;
    step(1'b0, 4'd0, 1'b1);
    chk("t3_direct_launch", obs_start[ja + 1], h_cyc + 1);
    wait_idle(100);

    // 4: stale done level carried into the next run is ignored
    set_job(4, 0, 8'hA5);
    jx = n_jobs;
    step(1'b1, 4'd12, 1'b1);
    set_job(9, 4, 8'h5A);
    jy = n_jobs;
    step(1'b1, 4'd13, 1'b1);
    wait_idle(100);
    chk("t4_first_result", obs_res[jx], 8'hA5);
    chk("t4_stale_ignored", obs_valid[jy] - obs_start[jy], 10);
    chk("t4_second_result", obs_res[jy], 8'h5A);

    // 5: timeout, then a normal job, then completion tying with the watchdog
    set_job(NEVER, 0, 0);
    jt = n_jobs;
    step(1'b1, 4'd14, 1'b1);
    set_job(3, 0, 8'h3C);
    jn = n_jobs;
    step(1'b1, 4'd15, 1'b1);
    set_job(TIMEOUT, 0, 8'h11);
    jz = n_jobs;
    step(1'b1, 4'd2, 1'b1);
    wait_idle(2000);
    chk("t5_timeout_latency", obs_valid[jt] - obs_start[jt], 256);
    chk("t5_timeout_result", obs_res[jt], 255);
    chk("t5_timeout_flag", obs_to[jt], 1);
    chk("t5_timeout_entry", obs_entry[jt], 14);
    chk("t5_next_launch", obs_start[jn] - obs_valid[jt], 1);
    chk("t5_next_result", obs_res[jn], 8'h3C);
    chk("t5_next_flag", obs_to[jn], 0);
    chk("t5_tie_result", obs_res[jz], 8'h11);
    chk("t5_tie_flag", obs_to[jz], 0);

    // 6: asynchronous reset in the middle of WAIT
    set_job(100, 0, 8'h77);
    step(1'b1, 4'd7, 1'b1);
    set_job(5, 0, 8'h78);
    step(1'b1, 4'd8, 1'b1);
    repeat (8) step(1'b0, 4'd0, 1'b1);
    chk("t6_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_fifo_count", fifo_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_core_start", core_start, 0);
    core_done = 1'b0;
    done_lvl  = 1'b0;
    first     = n_jobs;
    n_started = n_jobs;
    g_act     = -1;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    repeat (150) step(1'b0, 4'd0, 1'b1);

    // Random traffic
    nx_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 35, EW'($urandom), $urandom_range(0, 99) < 70);
    end
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
